// File: rtl/simproc.sv
// simproc: 8-bit multicycle load/store core, 4x8 register file, Z/N flags.
// One instruction = FETCH, DECODE, EXEC, WB; external combinational-read memory.

module simproc_rf (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ra,
   input  logic [1:0] rb,
   input  logic       we,
   input  logic [1:0] wa,
   input  logic [7:0] wd,
   output logic [7:0] da,
   output logic [7:0] db
);
   logic [7:0] rf [0:3];

   assign da = rf[ra];
   assign db = rf[rb];

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
      end else if (we) begin
         rf[wa] <= wd;
      end
   end
endmodule

module simproc (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] mem_dout,
   output logic [7:0] mem_din,
   output logic [7:0] mem_addr,
   output logic       mem_we,
   input  logic [7:0] pc_set_val,
   input  logic       pc_set_wr,
   input  logic       run,
   output logic       halt,
   output logic       done
);
   typedef enum logic [2:0] {
      IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXEC = 3'd3, WB = 3'd4, HALT = 3'd5
   } state_t;

   state_t     curr_state;
   logic [7:0] pc_out, ir, a_q, b_q, res_q;
   logic [1:0] dst_q;
   logic       wr_q, flg_q, z_flag, n_flag;

   logic [3:0] op;
   logic [1:0] rx, ry;
   logic       is_ori, is_shf, is_load, is_store, is_stop, br_taken;
   logic [7:0] rd_a, rd_b, alu;
   logic       alu_wr, alu_flg;

   assign op       = ir[3:0];
   assign rx       = ir[7:6];
   assign ry       = ir[5:4];
   assign is_ori   = (ir[2:0] == 3'b111);
   assign is_shf   = (ir[2:0] == 3'b011);
   assign is_load  = (op == 4'b0000);
   assign is_store = (op == 4'b0010);
   assign is_stop  = (op == 4'b1001);
   assign br_taken = ((op == 4'b1010) &&  z_flag) ||
                     ((op == 4'b0001) && !z_flag) ||
                     ((op == 4'b0101) && !n_flag);

   // ori always targets R1, so its imm bits overlap the Rx field
   simproc_rf RF1 (
      .clk (clk),
      .rst (rst),
      .ra  (is_ori ? 2'd1 : rx),
      .rb  (ry),
      .we  ((curr_state == WB) && wr_q),
      .wa  (dst_q),
      .wd  (res_q),
      .da  (rd_a),
      .db  (rd_b)
   );

   assign mem_addr = ((curr_state == EXEC) && (is_load || is_store)) ? b_q : pc_out;

   always_comb begin
      alu     = 8'h00;
      alu_wr  = 1'b0;
      alu_flg = 1'b0;
      if (is_ori) begin
         alu     = a_q | {3'b000, ir[7:3]};
         alu_wr  = 1'b1;
         alu_flg = 1'b1;
      end else if (is_shf) begin
         alu     = ir[5] ? (a_q >> ir[4:3]) : (a_q << ir[4:3]);
         alu_wr  = 1'b1;
         alu_flg = 1'b1;
      end else begin
         case (op)
            4'b0000: begin alu = mem_dout;       alu_wr = 1'b1; end
            4'b0100: begin alu = a_q + b_q;      alu_wr = 1'b1; alu_flg = 1'b1; end
            4'b0110: begin alu = a_q - b_q;      alu_wr = 1'b1; alu_flg = 1'b1; end
            4'b1000: begin alu = ~(a_q & b_q);   alu_wr = 1'b1; alu_flg = 1'b1; end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         curr_state <= IDLE;
         pc_out     <= pc_set_wr ? pc_set_val : 8'h00;
         ir         <= 8'h00;
         a_q        <= 8'h00;
         b_q        <= 8'h00;
         res_q      <= 8'h00;
         dst_q      <= 2'd0;
         wr_q       <= 1'b0;
         flg_q      <= 1'b0;
         z_flag     <= 1'b0;
         n_flag     <= 1'b0;
         mem_we     <= 1'b0;
         mem_din    <= 8'h00;
         done       <= 1'b0;
         halt       <= 1'b0;
      end else begin
         done   <= 1'b0;
         mem_we <= 1'b0;
         case (curr_state)
            IDLE: if (run) curr_state <= FETCH;
            FETCH: begin
               ir         <= mem_dout;
               pc_out     <= pc_out + 8'd1;
               curr_state <= DECODE;
            end
            DECODE: begin
               a_q <= rd_a;
               b_q <= rd_b;
               if (is_store) begin
                  mem_we  <= 1'b1;
                  mem_din <= rd_a;
               end
               curr_state <= EXEC;
            end
            EXEC: begin
               if (is_stop) begin
                  halt       <= 1'b1;
                  curr_state <= HALT;
               end else begin
                  res_q <= alu;
                  wr_q  <= alu_wr;
                  flg_q <= alu_flg;
                  dst_q <= is_ori ? 2'd1 : rx;
                  if (br_taken) pc_out <= pc_out + {{4{ir[7]}}, ir[7:4]};
                  done       <= 1'b1;
                  curr_state <= WB;
               end
            end
            WB: begin
               if (flg_q) begin
                  z_flag <= (res_q == 8'h00);
                  n_flag <= res_q[7];
               end
               curr_state <= run ? FETCH : IDLE;
            end
            HALT: if (!run) begin
               halt       <= 1'b0;
               curr_state <= IDLE;
            end
            default: curr_state <= IDLE;
         endcase
         // external PC load beats fetch increment and branch
         if (pc_set_wr) pc_out <= pc_set_val;
      end
   end
endmodule

// File: tb/tb_simproc.sv
// Directed bench for simproc: small programs in a bench-side memory,
// hand-computed register/flag/PC/memory results checked with immediate assertions.

module tb_simproc;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] mem_dout, mem_din, mem_addr, pc_set_val;
   logic       mem_we, pc_set_wr, run, halt, done;
   logic [7:0] mem [0:255];

   int npass = 0, ntotal = 0, nfail = 0;
   int last_k, nwe, ndone;
   logic we_bad;
   logic [7:0] we_addr, we_din;

   simproc dut (
      .clk        (clk),
      .rst        (rst),
      .mem_dout   (mem_dout),
      .mem_din    (mem_din),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .pc_set_val (pc_set_val),
      .pc_set_wr  (pc_set_wr),
      .run        (run),
      .halt       (halt),
      .done       (done)
   );

   always #5 clk = ~clk;

   assign mem_dout = mem[mem_addr];
   always @(posedge clk) if (mem_we) mem[mem_addr] = mem_din;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      ntotal++;
      assert (obs === exp) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      do begin @(negedge clk); k++; end while (done !== 1'b1 && k < 16);
      last_k = k;
      chk({tag, " done"}, {7'd0, done}, 8'd1);
   endtask

   task automatic run_to_halt(input string tag);
      int k = 0;
      nwe = 0; ndone = 0; we_bad = 1'b0; we_addr = 8'h00; we_din = 8'h00;
      do begin
         @(negedge clk); k++;
         if (mem_we) begin
            nwe++;
            if (8'(dut.curr_state) != 8'd3) we_bad = 1'b1;
            we_addr = mem_addr;
            we_din  = mem_din;
         end
         if (done) ndone++;
      end while (halt !== 1'b1 && k < 64);
      chk({tag, " halt"}, {7'd0, halt}, 8'd1);
   endtask

   task automatic do_reset(input logic [7:0] pc0);
      rst = 1'b0; run = 1'b0; pc_set_wr = 1'b1; pc_set_val = pc0;
      repeat (2) @(negedge clk);
      rst = 1'b1; pc_set_wr = 1'b0;
   endtask

   task automatic start_at(input logic [7:0] pc0);
      pc_set_wr = 1'b1; pc_set_val = pc0;
      @(negedge clk);
      pc_set_wr = 1'b0; run = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      // main loop program
      mem[8'h00] = 8'h90; mem[8'h01] = 8'h44; mem[8'h02] = 8'h47;
      mem[8'h03] = 8'hA8; mem[8'h04] = 8'h06; mem[8'h05] = 8'hDA;
      // prelude: R1 |= 1, stop
      mem[8'hF0] = 8'h0F; mem[8'hF1] = 8'h09;
      // store program and its data
      mem[8'h20] = 8'hF7; mem[8'h21] = 8'h10; mem[8'h22] = 8'h0F;
      mem[8'h23] = 8'h50; mem[8'h24] = 8'h42; mem[8'h25] = 8'h09;
      mem[8'h1E] = 8'hC0; mem[8'h1F] = 8'h5A;
      // branch program
      mem[8'h40] = 8'h0F; mem[8'h41] = 8'hDA; mem[8'h42] = 8'h11;
      mem[8'h43] = 8'h2F; mem[8'h44] = 8'h87; mem[8'h45] = 8'h09;
      // shift program and its data
      mem[8'h50] = 8'hE7; mem[8'h51] = 8'h10; mem[8'h52] = 8'h3B;
      mem[8'h53] = 8'h10; mem[8'h54] = 8'h0B; mem[8'h55] = 8'h09;
      mem[8'h1C] = 8'h81;

      // reset state, sampled while reset is still asserted
      rst = 1'b0; run = 1'b0; pc_set_wr = 1'b1; pc_set_val = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst state", 8'(dut.curr_state), 8'd0);
      chk("rst pc", dut.pc_out, 8'h00);
      chk("rst halt", {7'd0, halt}, 8'd0);
      chk("rst done", {7'd0, done}, 8'd0);
      chk("rst we", {7'd0, mem_we}, 8'd0);
      chk("rst din", mem_din, 8'h00);
      chk("rst addr", mem_addr, 8'h00);
      for (int i = 0; i < 4; i++) chk($sformatf("rst r%0d", i), dut.RF1.rf[i], 8'h00);
      rst = 1'b1; pc_set_wr = 1'b0;
      tick();

      // prelude sets R1 = 1
      start_at(8'hF0);
      run_to_halt("prelude");
      chk("prelude r1", dut.RF1.rf[1], 8'h01);
      chk("prelude dones", 8'(ndone), 8'd1);
      run = 1'b0; tick();

      // main program
      start_at(8'h00);
      wait_done("load"); tick(); chk("load r2", dut.RF1.rf[2], 8'h44);
      wait_done("add");  tick(); chk("add r1", dut.RF1.rf[1], 8'h01);
      wait_done("ori");  tick(); chk("ori r1", dut.RF1.rf[1], 8'h09);
      wait_done("nand"); tick(); chk("nand r2", dut.RF1.rf[2], 8'hBB);
      wait_done("sub");  tick(); chk("sub r0", dut.RF1.rf[0], 8'h00);
      chk("sub z", {7'd0, dut.z_flag}, 8'd1);
      wait_done("bz");   tick(); chk("bz target pc", dut.pc_out, 8'h03);
      wait_done("nand2");
      chk("done period", 8'(last_k), 8'd3);
      tick();
      chk("done width", {7'd0, done}, 8'd0);
      chk("nand2 r2", dut.RF1.rf[2], 8'h44);

      // redirect mid-run onto the stop at F1
      wait_done("sub2");
      pc_set_wr = 1'b1; pc_set_val = 8'hF1;
      tick();
      chk("redirect pc", dut.pc_out, 8'hF1);
      chk("redirect addr", mem_addr, 8'hF1);
      pc_set_wr = 1'b0;
      run_to_halt("stop");
      chk("stop no done", 8'(ndone), 8'd0);
      chk("stop state", 8'(dut.curr_state), 8'd5);
      repeat (5) tick();
      chk("halt hold state", 8'(dut.curr_state), 8'd5);
      chk("halt hold", {7'd0, halt}, 8'd1);
      run = 1'b0; tick();
      chk("unhalt state", 8'(dut.curr_state), 8'd0);
      chk("unhalt halt", {7'd0, halt}, 8'd0);

      // branches: bz not taken, bnz +1 taken
      do_reset(8'h40);
      chk("rst pc_set", dut.pc_out, 8'h40);
      run = 1'b1;
      wait_done("br ori");
      wait_done("bz nt"); tick(); chk("bz nt pc", dut.pc_out, 8'h42);
      wait_done("bnz");   tick(); chk("bnz pc", dut.pc_out, 8'h44);
      wait_done("br ori2"); tick(); chk("skip r1", dut.RF1.rf[1], 8'h11);
      run_to_halt("br stop");
      chk("br stop pc", dut.pc_out, 8'h46);
      run = 1'b0; tick();

      // store
      do_reset(8'h20);
      run = 1'b1;
      run_to_halt("st");
      chk("st we cycles", 8'(nwe), 8'd1);
      chk("st we in exec", {7'd0, we_bad}, 8'd0);
      chk("st addr", we_addr, 8'hC0);
      chk("st din", we_din, 8'h5A);
      chk("st mem", mem[8'hC0], 8'h5A);
      chk("st dones", 8'(ndone), 8'd5);
      chk("st r0", dut.RF1.rf[0], 8'hC0);
      run = 1'b0; tick();

      // shifts
      do_reset(8'h50);
      run = 1'b1;
      wait_done("sh ori");
      wait_done("sh ld"); tick(); chk("sh ld r0", dut.RF1.rf[0], 8'h81);
      wait_done("shr");   tick(); chk("shr r0", dut.RF1.rf[0], 8'h10);
      chk("shr n", {7'd0, dut.n_flag}, 8'd0);
      chk("shr z", {7'd0, dut.z_flag}, 8'd0);
      wait_done("sh ld2");
      wait_done("shl");   tick(); chk("shl r0", dut.RF1.rf[0], 8'h02);
      run_to_halt("sh stop");
      run = 1'b0; tick();

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end
endmodule

// File: doc/simproc.md
Name: simproc

Overview:
- 8-bit multicycle accumulator-free load/store processor with a 4×8-bit register file (R0–R3), an 8-bit PC, and Z/N condition flags.
- Drives a single external 256×8 memory port:
  - Read is combinational: mem_dout = mem[mem_addr].
  - Write is synchronous on mem_we.
- Started and stopped by a run level, with an externally loadable PC. Sits as the compute core beside a testbench- or SoC-supplied memory.

Parameters:
- None. Data width 8, address width 8, 4 registers, all fixed.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-low reset
- mem_dout  input  8  memory read data for mem_addr (combinational)
- mem_din  output  8  memory write data
- mem_addr  output  8  memory address
- mem_we  output  1  memory write enable, sampled at posedge clk
- pc_set_val  input  8  value loaded into PC when pc_set_wr=1
- pc_set_wr  input  1  PC load strobe
- run  input  1  level; 1 = execute instructions
- halt  output  1  1 while in HALT state
- done  output  1  1-cycle pulse at end of every completed instruction

Behaviour:
- Reset (rst=0 at posedge):
  - State IDLE; PC=0 (or pc_set_val if pc_set_wr=1 same cycle); R0–R3=0; Z=N=0; IR=0.
  - Outputs: mem_we=0, done=0, halt=0, mem_addr=PC, mem_din=0.
  - Reset mid-instruction aborts it; no memory write is issued.
- Internal names: register file instance RF1 with array rf[0:3]; state register curr_state; PC value pc_out.
- curr_state encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, WB=4, HALT=5.
- State transitions:
  - IDLE: go to FETCH when run=1.
  - FETCH: mem_addr=PC; IR<=mem_dout; PC<=PC+1 (8-bit wrap).
  - DECODE: read Rx=IR[7:6], Ry=IR[5:4].
  - EXEC:
    - load: mem_addr=Ry.
    - store: mem_addr=Ry, mem_din=Rx, mem_we=1.
    - ALU ops: compute result.
    - taken branch: PC<=PC+sext(IR[7:4]).
  - WB: write result to destination, update flags, done=1. Then FETCH if run=1, else IDLE.
  - stop: EXEC→HALT with no WB and no done.
  - HALT: halt=1; go to IDLE when run=0.
- Each instruction takes 4 cycles from FETCH entry to the next FETCH. FETCH is the instruction boundary.
- pc_set_wr=1 loads PC<=pc_set_val in any state, overriding FETCH increment and branch.
- mem_addr=PC in all states except EXEC of load/store. mem_we is 1 only in EXEC of store.
- ISA, opcode IR[3:0] unless noted:
  - 0000 load Rx,(Ry): Rx<=mem[Ry]; flags unchanged.
  - 0010 store Rx,(Ry): mem[Ry]<=Rx.
  - 0100 add Rx,Ry: Rx<=Rx+Ry (mod 256).
  - 0110 sub Rx,Ry: Rx<=Rx−Ry (mod 256).
  - 1000 nand Rx,Ry: Rx<=~(Rx&Ry).
  - IR[2:0]=111 ori imm5: R1<=R1|{000,IR[7:3]}.
  - IR[2:0]=011 shift Rx: IR[5]=0 left / 1 logical right, by amount IR[4:3] (0–3).
  - 1010 bz imm4: taken if Z=1.
  - 0001 bnz imm4: taken if Z=0.
  - 0101 bpz imm4: taken if N=0.
  - 1001 stop.
  - 1101 and all other codes: nop.
- Branch offset: imm4=IR[7:4], signed two's complement, relative to the already-incremented PC.
- Flags:
  - add, sub, nand, ori and shift update Z=(result==0) and N=result[7].
  - load, store, branches and nop leave flags unchanged.
- Overflow wraps; no carry flag.

Test Plan:
- Reset with pc_set_wr=1, pc_set_val=0 → curr_state=0, PC=0, halt=0, done=0, all rf=0.
- Run program mem[0..5]=90,44,47,A8,06,DA with R1=1, run=1 held:
  - after load: R2=44.
  - after add: R1=01.
  - after ori: R1=09.
  - after nand: R2=BB.
  - after sub: R0=00, Z=1.
  - bz at PC=5 jumps to 3: next nand gives R2=44, looping forever.
  - done pulses every 4 cycles.
- Store: R0=C0, R1=5A, instr 0100_0010 → mem[C0]=5A; mem_we high exactly 1 cycle, in EXEC.
- Branch not taken: Z=0, bz imm=−3 → PC advances sequentially. bnz with Z=0 and imm=+1 skips one instruction.
- Shift: R0=81, 0011_1011 (right by 3) → R0=10, N=0. 0000_1011 (left by 1) on 81 → 02.
- Stop: 0000_1001 → halt=1 and state stays HALT while run=1; run=0 → IDLE, halt=0. pc_set_wr mid-run redirects the next fetch to pc_set_val.
